// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding (common to TX and RX) and parity helper.
// Latency: n/a (package).
// Backpressure: n/a (package).
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'b000,
        START  = 3'b001,
        DATA   = 3'b010,
        PARITY = 3'b011,
        STOP   = 3'b100
    } uart_state_t;

    // Even parity over up to 32 data bits; callers zero-extend narrower words.
    function automatic logic even_parity(input logic [31:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Brings the asynchronous rx line into clk and flags its falling edges.
// Latency: rx pin to rx_s is 2 clk; fall_edge is valid in the cycle rx_s first reads 0.
// Backpressure: none; free-running.
// Ports: clk, reset (sync, active-high), rx (async, idle high),
//        rx_s (synchronized line), fall_edge (rx_d==1 && rx_s==0).
module uart_rx_sync (
    input  logic clk,
    input  logic reset,
    input  logic rx,
    output logic rx_s,
    output logic fall_edge
);

    logic rx_meta;
    logic rx_d;

    // All three flops reset to the idle level so reset never fakes an edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
            rx_d    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
            rx_d    <= rx_s;
        end
    end

    assign fall_edge = rx_d & ~rx_s;

endmodule

// File: rtl/uart_rx.sv
// UART receiver: start + DATA_BITS (LSB first) + even parity + stop, 16x oversampled, mid-bit sampling.
// Latency: rx_done_tick 1 clk after the stop-bit sampling tick (plus 2 clk input synchronizer).
// Backpressure: none; each frame is delivered once on rx_done_tick and the host must take it.
// Ports: clk, reset (sync, active-high), rx (serial in), timer_tick (baud tick),
//        baudrate_gen_en (baud generator enable), rx_dout, rx_done_tick, parity_err, frame_err.
module uart_rx
    import uart_pkg::*;
#(
    parameter int DATA_BITS         = 4,
    parameter int TICKS_PER_DATABIT = 16,
    parameter int STOP_BIT_TICKS    = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 rx,
    input  logic                 timer_tick,
    output logic                 baudrate_gen_en,
    output logic [DATA_BITS-1:0] rx_dout,
    output logic                 rx_done_tick,
    output logic                 parity_err,
    output logic                 frame_err
);

    localparam int BCW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    localparam logic [5:0]     HALF_CNT = 6'(TICKS_PER_DATABIT / 2 - 1);
    localparam logic [5:0]     BIT_CNT  = 6'(TICKS_PER_DATABIT - 1);
    localparam logic [5:0]     STOP_CNT = 6'(STOP_BIT_TICKS - 1);
    localparam logic [BCW-1:0] LAST_BIT = BCW'(DATA_BITS - 1);

    uart_state_t          state;
    logic [5:0]           tick_cnt;
    logic [BCW-1:0]       bit_cnt;
    logic [DATA_BITS-1:0] shreg;
    logic                 par_bit;
    logic                 rx_s;
    logic                 fall_edge;
    logic [DATA_BITS:0]   shift_in;

    uart_rx_sync u_sync (
        .clk       (clk),
        .reset     (reset),
        .rx        (rx),
        .rx_s      (rx_s),
        .fall_edge (fall_edge)
    );

    // Right shift with the new bit entering at the MSB; written this way so
    // DATA_BITS==1 needs no special case.
    assign shift_in = {rx_s, shreg};

    assign baudrate_gen_en = (state != IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            tick_cnt     <= '0;
            bit_cnt      <= '0;
            shreg        <= '0;
            par_bit      <= 1'b0;
            rx_dout      <= '0;
            rx_done_tick <= 1'b0;
            parity_err   <= 1'b0;
            frame_err    <= 1'b0;
        end else begin
            rx_done_tick <= 1'b0;
            case (state)
                IDLE: begin
                    // Only an edge starts a frame; a line stuck low is ignored.
                    tick_cnt <= '0;
                    if (fall_edge) begin
                        state <= START;
                    end
                end
                START: begin
                    if (timer_tick && tick_cnt == HALF_CNT) begin
                        tick_cnt <= '0;
                        bit_cnt  <= '0;
                        // Line back high at mid start bit: treat as a glitch.
                        state    <= rx_s ? IDLE : DATA;
                    end else if (timer_tick) begin
                        tick_cnt <= tick_cnt + 6'd1;
                    end
                end
                DATA: begin
                    if (timer_tick && tick_cnt == BIT_CNT) begin
                        shreg <= shift_in[DATA_BITS:1];
                        if (bit_cnt == LAST_BIT) begin
                            tick_cnt <= '0;
                            state    <= PARITY;
                        end else begin
                            tick_cnt <= '0;
                            bit_cnt  <= bit_cnt + 1'b1;
                        end
                    end else if (timer_tick) begin
                        tick_cnt <= tick_cnt + 6'd1;
                    end
                end
                PARITY: begin
                    if (timer_tick && tick_cnt == BIT_CNT) begin
                        par_bit  <= rx_s;
                        tick_cnt <= '0;
                        state    <= STOP;
                    end else if (timer_tick) begin
                        tick_cnt <= tick_cnt + 6'd1;
                    end
                end
                STOP: begin
                    // Leaving at mid stop bit lets the next start edge in immediately.
                    if (timer_tick && tick_cnt == STOP_CNT) begin
                        rx_dout      <= shreg;
                        parity_err   <= par_bit ^ even_parity(32'(shreg));
                        frame_err    <= ~rx_s;
                        rx_done_tick <= 1'b1;
                        tick_cnt     <= '0;
                        state        <= IDLE;
                    end else if (timer_tick) begin
                        tick_cnt <= tick_cnt + 6'd1;
                    end
                end
                default: begin
                    tick_cnt <= '0;
                    state    <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
module tb_uart_rx;

    localparam int BIT_CLKS = 64;   // 16 ticks x 4 clk

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       rx = 1'b1;
    logic       timer_tick = 1'b0;
    logic       baudrate_gen_en;
    logic [3:0] rx_dout;
    logic       rx_done_tick;
    logic       parity_err;
    logic       frame_err;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    logic [5:0] rxq[$];   // {parity_err, frame_err, rx_dout} per strobe

    uart_rx #(
        .DATA_BITS(4),
        .TICKS_PER_DATABIT(16),
        .STOP_BIT_TICKS(16)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .rx              (rx),
        .timer_tick      (timer_tick),
        .baudrate_gen_en (baudrate_gen_en),
        .rx_dout         (rx_dout),
        .rx_done_tick    (rx_done_tick),
        .parity_err      (parity_err),
        .frame_err       (frame_err)
    );

    always #5 clk = ~clk;

    // One-clk tick every 4 clk, changed on the falling edge.
    initial begin
        forever begin
            repeat (3) @(negedge clk);
            timer_tick = 1'b1;
            @(negedge clk);
            timer_tick = 1'b0;
        end
    end

    // Strobe monitor, sampled on the falling edge.
    initial begin
        forever begin
            @(negedge clk);
            if (rx_done_tick === 1'b1) begin
                done_cnt = done_cnt + 1;
                rxq.push_back({parity_err, frame_err, rx_dout});
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bit(input logic b);
        rx = b;
        idle(BIT_CLKS);
    endtask

    task automatic send_frame(input logic [3:0] d, input logic par, input logic stp);
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(d[i]);
        send_bit(par);
        send_bit(stp);
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset = 1'b1;
        idle(4);
        checks++; if (rx_dout !== 4'h0) begin errors++; $display("FAIL reset_dout got=%h exp=0", rx_dout); end
        checks++; if (rx_done_tick !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", rx_done_tick); end
        checks++; if (parity_err !== 1'b0) begin errors++; $display("FAIL reset_perr got=%b exp=0", parity_err); end
        checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_ferr got=%b exp=0", frame_err); end
        checks++; if (baudrate_gen_en !== 1'b0) begin errors++; $display("FAIL reset_en got=%b exp=0", baudrate_gen_en); end
        reset = 1'b0;
        idle(20);
    endtask

    task automatic test_good_frame();
        int c0;
        c0 = done_cnt;
        checks++; if (baudrate_gen_en !== 1'b0) begin errors++; $display("FAIL good_en_pre got=%b exp=0", baudrate_gen_en); end
        send_bit(1'b0);
        checks++; if (baudrate_gen_en !== 1'b1) begin errors++; $display("FAIL good_en_mid got=%b exp=1", baudrate_gen_en); end
        send_bit(1'b0); send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);   // 4'hA LSB first
        send_bit(1'b0);                                                    // parity
        send_bit(1'b1);                                                    // stop
        idle(40);
        checks++; if (done_cnt - c0 !== 1) begin errors++; $display("FAIL good_strobes got=%0d exp=1", done_cnt - c0); end
        checks++; if (rx_dout !== 4'hA) begin errors++; $display("FAIL good_dout got=%h exp=a", rx_dout); end
        checks++; if (parity_err !== 1'b0) begin errors++; $display("FAIL good_perr got=%b exp=0", parity_err); end
        checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL good_ferr got=%b exp=0", frame_err); end
        checks++; if (baudrate_gen_en !== 1'b0) begin errors++; $display("FAIL good_en_post got=%b exp=0", baudrate_gen_en); end
    endtask

    task automatic test_parity_err();
        int c0;
        c0 = done_cnt;
        send_frame(4'h7, 1'b0, 1'b1);   // correct parity would be 1
        idle(40);
        checks++; if (done_cnt - c0 !== 1) begin errors++; $display("FAIL par_strobes got=%0d exp=1", done_cnt - c0); end
        checks++; if (rx_dout !== 4'h7) begin errors++; $display("FAIL par_dout got=%h exp=7", rx_dout); end
        checks++; if (parity_err !== 1'b1) begin errors++; $display("FAIL par_perr got=%b exp=1", parity_err); end
        checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL par_ferr got=%b exp=0", frame_err); end
    endtask

    task automatic test_frame_err();
        int c0;
        c0 = done_cnt;
        send_frame(4'h3, 1'b0, 1'b0);
        rx = 1'b0;                      // line stays low
        idle(600);
        checks++; if (done_cnt - c0 !== 1) begin errors++; $display("FAIL ferr_strobes got=%0d exp=1", done_cnt - c0); end
        checks++; if (rx_dout !== 4'h3) begin errors++; $display("FAIL ferr_dout got=%h exp=3", rx_dout); end
        checks++; if (frame_err !== 1'b1) begin errors++; $display("FAIL ferr_ferr got=%b exp=1", frame_err); end
        checks++; if (parity_err !== 1'b0) begin errors++; $display("FAIL ferr_perr got=%b exp=0", parity_err); end
        checks++; if (baudrate_gen_en !== 1'b0) begin errors++; $display("FAIL ferr_en_low got=%b exp=0", baudrate_gen_en); end
        rx = 1'b1;
        idle(100);
        checks++; if (done_cnt - c0 !== 1) begin errors++; $display("FAIL ferr_no_second got=%0d exp=1", done_cnt - c0); end
    endtask

    task automatic test_glitch();
        int c0;
        c0 = done_cnt;
        rx = 1'b0;
        idle(12);                       // 3 ticks low
        rx = 1'b1;
        idle(200);
        checks++; if (done_cnt - c0 !== 0) begin errors++; $display("FAIL glitch_strobes got=%0d exp=0", done_cnt - c0); end
        checks++; if (rx_dout !== 4'h3) begin errors++; $display("FAIL glitch_dout got=%h exp=3", rx_dout); end
        checks++; if (frame_err !== 1'b1) begin errors++; $display("FAIL glitch_ferr got=%b exp=1", frame_err); end
        checks++; if (parity_err !== 1'b0) begin errors++; $display("FAIL glitch_perr got=%b exp=0", parity_err); end
        checks++; if (baudrate_gen_en !== 1'b0) begin errors++; $display("FAIL glitch_en got=%b exp=0", baudrate_gen_en); end
    endtask

    task automatic test_back_to_back();
        int c0;
        int n0;
        c0 = done_cnt;
        n0 = rxq.size();
        send_frame(4'h5, 1'b0, 1'b1);
        send_frame(4'hC, 1'b0, 1'b1);
        idle(40);
        checks++; if (done_cnt - c0 !== 2) begin errors++; $display("FAIL b2b_strobes got=%0d exp=2", done_cnt - c0); end
        if (rxq.size() >= n0 + 2) begin
            checks++; if (rxq[n0] !== 6'h05) begin errors++; $display("FAIL b2b_first got=%h exp=05", rxq[n0]); end
            checks++; if (rxq[n0+1] !== 6'h0C) begin errors++; $display("FAIL b2b_second got=%h exp=0c", rxq[n0+1]); end
        end else begin
            checks++; errors++;
            $display("FAIL b2b_queue got=%0d exp=%0d", rxq.size(), n0 + 2);
        end
    endtask

    task automatic test_reset_mid();
        int c0;
        c0 = done_cnt;
        send_bit(1'b0);
        send_bit(1'b1); send_bit(1'b0);
        rx = 1'b1;                      // bit 2
        idle(32);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checks++; if (rx_dout !== 4'h0) begin errors++; $display("FAIL rmid_dout got=%h exp=0", rx_dout); end
        checks++; if (parity_err !== 1'b0) begin errors++; $display("FAIL rmid_perr got=%b exp=0", parity_err); end
        checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL rmid_ferr got=%b exp=0", frame_err); end
        checks++; if (rx_done_tick !== 1'b0) begin errors++; $display("FAIL rmid_done got=%b exp=0", rx_done_tick); end
        checks++; if (baudrate_gen_en !== 1'b0) begin errors++; $display("FAIL rmid_en got=%b exp=0", baudrate_gen_en); end
        idle(400);
        checks++; if (done_cnt - c0 !== 0) begin errors++; $display("FAIL rmid_no_strobe got=%0d exp=0", done_cnt - c0); end
        send_frame(4'h9, 1'b0, 1'b1);
        idle(40);
        checks++; if (done_cnt - c0 !== 1) begin errors++; $display("FAIL rmid_strobes got=%0d exp=1", done_cnt - c0); end
        checks++; if (rx_dout !== 4'h9) begin errors++; $display("FAIL rmid_next_dout got=%h exp=9", rx_dout); end
        checks++; if (parity_err !== 1'b0 || frame_err !== 1'b0) begin
            errors++; $display("FAIL rmid_next_errs got=%b%b exp=00", parity_err, frame_err);
        end
    endtask

    initial begin
        test_reset();
        test_good_frame();
        test_parity_err();
        test_frame_err();
        test_glitch();
        test_back_to_back();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
